// File: rtl/axi_mem_responder_pkg.sv
// rtl/axi_mem_responder_pkg.sv - shared response codes, FSM state types and stall LFSR helper
//
// Purpose: common definitions imported by axi_mem_responder and its RAM.
// Contents:
//   RESP_OKAY / RESP_SLVERR  AXI response encodings
//   r_state_e                read FSM states
//   w_state_e                write FSM states
//   LFSR_SEED / lfsr_next    stall-pattern generator used when
//                            AXI_MEM_RESPONDER_RAND_STALL_EN is defined
package axi_mem_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11 (bit n of the polynomial is s[n-1]).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// rtl/axi_mem_responder_ram.sv - flop memory with one byte-enabled write port and two async read ports
//
// Purpose: backing store for axi_mem_responder. Contents are not reset.
// Ports:
//   clk              write clock
//   we               write enable (one word per cycle)
//   waddr            write word index
//   wdata / wstrb    write data and per-byte enables
//   raddr_a/rdata_a  asynchronous read port A
//   raddr_b/rdata_b  asynchronous read port B
// Reads return the value before any write committed on the same edge.
module axi_mem_responder_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic [$clog2(DEPTH)-1:0]      raddr_a,
  output logic [DATA_WIDTH-1:0]         rdata_a,
  input  logic [$clog2(DEPTH)-1:0]      raddr_b,
  output logic [DATA_WIDTH-1:0]         rdata_b
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 INCR-burst memory responder with independent read and write paths
//
// Purpose: terminates an AXI4 manager port with a DEPTH x AXI_DATA_WIDTH flop
// memory. Full-width INCR beats only; IDs are echoed; addresses beyond the
// memory answer SLVERR (reads return 0, writes are dropped). Burst indices
// wrap modulo DEPTH without error.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   axi_req_i_aw_* / axi_resp_o_aw_ready   write address channel
//   axi_req_i_w_*  / axi_resp_o_w_ready    write data channel
//   axi_resp_o_b_* / axi_req_i_b_ready     write response channel
//   axi_req_i_ar_* / axi_resp_o_ar_ready   read address channel
//   axi_resp_o_r_* / axi_req_i_r_ready     read data channel
// Build option: AXI_MEM_RESPONDER_RAND_STALL_EN inserts pseudo-random stalls
// on r_valid and w_ready driven by a 16-bit LFSR.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DEPTH          = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        axi_req_i_aw_valid,
  output logic                        axi_resp_o_aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_req_i_aw_bits_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_req_i_aw_bits_addr,
  input  logic [7:0]                  axi_req_i_aw_bits_len,
  input  logic                        axi_req_i_w_valid,
  output logic                        axi_resp_o_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_req_i_w_bits_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_req_i_w_bits_strb,
  input  logic                        axi_req_i_w_bits_last,
  output logic                        axi_resp_o_b_valid,
  input  logic                        axi_req_i_b_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_resp_o_b_bits_id,
  output logic [1:0]                  axi_resp_o_b_bits_resp,
  input  logic                        axi_req_i_ar_valid,
  output logic                        axi_resp_o_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_req_i_ar_bits_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_req_i_ar_bits_addr,
  input  logic [7:0]                  axi_req_i_ar_bits_len,
  output logic                        axi_resp_o_r_valid,
  input  logic                        axi_req_i_r_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_resp_o_r_bits_id,
  output logic [AXI_DATA_WIDTH-1:0]   axi_resp_o_r_bits_data,
  output logic [1:0]                  axi_resp_o_r_bits_resp,
  output logic                        axi_resp_o_r_bits_last
);

  localparam int OFS = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX = $clog2(DEPTH);

  // Address byte-offset bits carry no information for full-width beats.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{axi_req_i_aw_bits_addr[OFS-1:0], axi_req_i_ar_bits_addr[OFS-1:0]};

  // Ready outputs must stay low while reset is asserted; this flop opens
  // the address channels on the first edge after release.
  logic rst_done;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  logic stall;
`ifdef AXI_MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [IDX-1:0]            r_idx_q;
  logic [IDX-1:0]            r_idx_next;
  logic [7:0]                r_len_q, r_cnt_q;
  logic                      r_err_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic                      r_last;
  logic                      ar_hs, r_hs, ar_err;
  logic [IDX-1:0]            ar_idx;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata_start, ram_rdata_next;

  assign ar_idx     = axi_req_i_ar_bits_addr[OFS +: IDX];
  assign ar_err     = |axi_req_i_ar_bits_addr[AXI_ADDR_WIDTH-1:OFS+IDX];
  assign r_idx_next = r_idx_q + 1'b1;

  always_comb begin
    r_state_d           = r_state_q;
    axi_resp_o_ar_ready = 1'b0;
    axi_resp_o_r_valid  = 1'b0;
    r_last              = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        axi_resp_o_ar_ready = rst_done;
        if (rst_done && axi_req_i_ar_valid) r_state_d = R_BURST;
      end
      R_BURST: begin
        axi_resp_o_r_valid = !stall;
        r_last             = (r_cnt_q == r_len_q);
        if (!stall && axi_req_i_r_ready && r_last) r_state_d = R_IDLE;
      end
    endcase
  end

  assign ar_hs = axi_resp_o_ar_ready & axi_req_i_ar_valid;
  assign r_hs  = axi_resp_o_r_valid & axi_req_i_r_ready;

  // r_data is registered from the asynchronous RAM port, so a write landing
  // on the same edge is not visible until the following beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q   <= axi_req_i_ar_bits_id;
        r_idx_q  <= ar_idx;
        r_len_q  <= axi_req_i_ar_bits_len;
        r_cnt_q  <= '0;
        r_err_q  <= ar_err;
        r_data_q <= ar_err ? '0 : ram_rdata_start;
      end else if (r_hs) begin
        r_idx_q  <= r_idx_next;
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_data_q <= r_err_q ? '0 : ram_rdata_next;
      end
    end
  end

  assign axi_resp_o_r_bits_id   = r_id_q;
  assign axi_resp_o_r_bits_data = r_data_q;
  assign axi_resp_o_r_bits_resp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi_resp_o_r_bits_last = r_last;

  // --------------------------------------------------------------- write path
  w_state_e                w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0] w_id_q;
  logic [IDX-1:0]          w_idx_q;
  logic [7:0]              w_len_q;
  // One extra bit so beats past len=255 are still recognised as surplus.
  logic [8:0]              w_cnt_q;
  logic                    w_err_q;
  logic [1:0]              b_resp_q;
  logic                    aw_hs, w_hs, aw_err, w_in_len, mem_we;

  assign aw_err   = |axi_req_i_aw_bits_addr[AXI_ADDR_WIDTH-1:OFS+IDX];
  assign w_in_len = (w_cnt_q <= {1'b0, w_len_q});

  always_comb begin
    w_state_d           = w_state_q;
    axi_resp_o_aw_ready = 1'b0;
    axi_resp_o_w_ready  = 1'b0;
    axi_resp_o_b_valid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        axi_resp_o_aw_ready = rst_done;
        if (rst_done && axi_req_i_aw_valid) w_state_d = W_DATA;
      end
      W_DATA: begin
        axi_resp_o_w_ready = !stall;
        if (!stall && axi_req_i_w_valid && axi_req_i_w_bits_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        axi_resp_o_b_valid = 1'b1;
        if (axi_req_i_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs  = axi_resp_o_aw_ready & axi_req_i_aw_valid;
  assign w_hs   = axi_resp_o_w_ready & axi_req_i_w_valid;
  // Out-of-range bursts and surplus beats leave memory untouched.
  assign mem_we = w_hs & ~w_err_q & w_in_len;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_id_q  <= axi_req_i_aw_bits_id;
        w_idx_q <= axi_req_i_aw_bits_addr[OFS +: IDX];
        w_len_q <= axi_req_i_aw_bits_len;
        w_cnt_q <= '0;
        w_err_q <= aw_err;
      end else if (w_hs) begin
        w_idx_q <= w_idx_q + 1'b1;
        if (!w_cnt_q[8]) w_cnt_q <= w_cnt_q + 9'd1;
        if (axi_req_i_w_bits_last) begin
          b_resp_q <= (w_err_q || (w_cnt_q != {1'b0, w_len_q})) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  assign axi_resp_o_b_bits_id   = w_id_q;
  assign axi_resp_o_b_bits_resp = b_resp_q;

  // ---------------------------------------------------------------- storage
  // Port A serves the first beat at AR handshake, port B the next beat.
  axi_mem_responder_ram #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk_i),
    .we      (mem_we),
    .waddr   (w_idx_q),
    .wdata   (axi_req_i_w_bits_data),
    .wstrb   (axi_req_i_w_bits_strb),
    .raddr_a (ar_idx),
    .rdata_a (ram_rdata_start),
    .raddr_b (r_idx_next),
    .rdata_b (ram_rdata_next)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
module tb_axi_mem_responder;

  localparam int IDW   = 5;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            aw_valid = 1'b0, aw_ready;
  logic [IDW-1:0]  aw_id = '0;
  logic [AW-1:0]   aw_addr = '0;
  logic [7:0]      aw_len = '0;
  logic            w_valid = 1'b0, w_ready;
  logic [DW-1:0]   w_data = '0;
  logic [NB-1:0]   w_strb = '0;
  logic            w_last = 1'b0;
  logic            b_valid, b_ready = 1'b0;
  logic [IDW-1:0]  b_id;
  logic [1:0]      b_resp;
  logic            ar_valid = 1'b0, ar_ready;
  logic [IDW-1:0]  ar_id = '0;
  logic [AW-1:0]   ar_addr = '0;
  logic [7:0]      ar_len = '0;
  logic            r_valid, r_ready = 1'b0;
  logic [IDW-1:0]  r_id;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_last;

  axi_mem_responder dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .axi_req_i_aw_valid     (aw_valid),
    .axi_resp_o_aw_ready    (aw_ready),
    .axi_req_i_aw_bits_id   (aw_id),
    .axi_req_i_aw_bits_addr (aw_addr),
    .axi_req_i_aw_bits_len  (aw_len),
    .axi_req_i_w_valid      (w_valid),
    .axi_resp_o_w_ready     (w_ready),
    .axi_req_i_w_bits_data  (w_data),
    .axi_req_i_w_bits_strb  (w_strb),
    .axi_req_i_w_bits_last  (w_last),
    .axi_resp_o_b_valid     (b_valid),
    .axi_req_i_b_ready      (b_ready),
    .axi_resp_o_b_bits_id   (b_id),
    .axi_resp_o_b_bits_resp (b_resp),
    .axi_req_i_ar_valid     (ar_valid),
    .axi_resp_o_ar_ready    (ar_ready),
    .axi_req_i_ar_bits_id   (ar_id),
    .axi_req_i_ar_bits_addr (ar_addr),
    .axi_req_i_ar_bits_len  (ar_len),
    .axi_resp_o_r_valid     (r_valid),
    .axi_req_i_r_ready      (r_ready),
    .axi_resp_o_r_bits_id   (r_id),
    .axi_resp_o_r_bits_data (r_data),
    .axi_resp_o_r_bits_resp (r_resp),
    .axi_resp_o_r_bits_last (r_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } r_exp_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } b_exp_t;

  r_exp_t        r_q[$];
  b_exp_t        b_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf_d [256];
  logic [NB-1:0] wbuf_s [256];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int bp_mode = 0;   // 0: always ready, 1: random, 2: slow fixed pattern

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model rules: byte address -> word (addr/8) mod DEPTH,
  // anything at or above DEPTH*NB bytes is an error burst.
  function automatic bit addr_bad(input logic [AW-1:0] a);
    return a >= 64'(DEPTH * NB);
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a / NB) % DEPTH);
  endfunction

  // Ready drivers for the response channels.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       begin r_ready = 1'b1; b_ready = 1'b1; end
        1:       begin r_ready = ($urandom_range(0, 3) != 0); b_ready = ($urandom_range(0, 2) != 0); end
        default: begin r_ready = (cyc % 4 == 3); b_ready = (cyc % 5 == 4); end
      endcase
    end
  end

  // Monitor: pops expectations on every handshake and checks that stalled
  // payloads are held.
  r_exp_t hold_r;
  b_exp_t hold_b;
  bit     r_held = 0;
  bit     b_held = 0;

  always @(negedge clk) begin
    r_exp_t e;
    b_exp_t f;
    if (rst) begin
      r_held = 0;
      b_held = 0;
    end else begin
      if (r_held) begin
        check("r_stall_valid", r_valid, 1'b1);
        check("r_stall_payload", {r_id, r_data, r_resp, r_last},
              {hold_r.id, hold_r.data, hold_r.resp, hold_r.last});
      end
      r_held = r_valid && !r_ready;
      if (r_held) begin
        hold_r.id = r_id; hold_r.data = r_data; hold_r.resp = r_resp; hold_r.last = r_last;
      end
      if (r_valid && r_ready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=beat id %0h required=no beat", r_id);
        end else begin
          e = r_q.pop_front();
          check("r_id", r_id, e.id);
          check("r_data", r_data, e.data);
          check("r_resp", r_resp, e.resp);
          check("r_last", r_last, e.last);
        end
      end

      if (b_held) begin
        check("b_stall_valid", b_valid, 1'b1);
        check("b_stall_payload", {b_id, b_resp}, {hold_b.id, hold_b.resp});
      end
      b_held = b_valid && !b_ready;
      if (b_held) begin
        hold_b.id = b_id; hold_b.resp = b_resp;
      end
      if (b_valid) check("aw_ready_during_b", aw_ready, 1'b0);
      if (b_valid && b_ready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=resp id %0h required=no response", b_id);
        end else begin
          f = b_q.pop_front();
          check("b_id", b_id, f.id);
          check("b_resp", b_resp, f.resp);
        end
      end
    end
  end

  // Returns just after the clock edge on which the channel handshook.
  task automatic wait_ready(input int ch, input string name);
    int n = 0;
    bit rdy;
    forever begin
      @(negedge clk);
      case (ch)
        0:       rdy = aw_ready;
        1:       rdy = w_ready;
        default: rdy = ar_ready;
      endcase
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL %s actual=no handshake required=handshake within 200 cycles", name);
        break;
      end
    end
  endtask

  task automatic wait_q_empty(input bit is_b, input string name);
    int n = 0;
    while (((is_b ? b_q.size() : r_q.size()) != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if ((is_b ? b_q.size() : r_q.size()) != 0) begin
      checks++; errors++;
      $display("FAIL %s actual=responses outstanding required=drained within 2000 cycles", name);
    end
    #1;
  endtask

  // Write burst from wbuf_d/wbuf_s[0..nbeats-1]; model updated at issue.
  task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input int nbeats, input bit wait_b);
    b_exp_t f;
    bit     bad  = addr_bad(addr);
    int     base = word_of(addr);
    for (int i = 0; i < nbeats; i++) begin
      if (!bad && i <= len) begin
        for (int b = 0; b < NB; b++) begin
          if (wbuf_s[i][b]) ref_mem[(base + i) % DEPTH][b*8 +: 8] = wbuf_d[i][b*8 +: 8];
        end
      end
    end
    f.id   = id;
    f.resp = (bad || (nbeats - 1 != len)) ? 2'b10 : 2'b00;
    b_q.push_back(f);

    @(posedge clk);
    #1;
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = 8'(len);
    wait_ready(0, "aw_handshake");
    aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      w_valid = 1'b1; w_data = wbuf_d[i]; w_strb = wbuf_s[i]; w_last = (i == nbeats - 1);
      wait_ready(1, "w_handshake");
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    @(negedge clk);
    check("b_latency", b_valid, 1'b1);
    if (wait_b) wait_q_empty(1'b1, "b_drain");
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input int len, input bit wait_r);
    r_exp_t e;
    bit     bad  = addr_bad(addr);
    int     base = word_of(addr);
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.data = bad ? '0 : ref_mem[(base + i) % DEPTH];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (i == len);
      r_q.push_back(e);
    end
    @(posedge clk);
    #1;
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
    wait_ready(2, "ar_handshake");
    ar_valid = 1'b0;
    @(negedge clk);
    check("r_latency", r_valid, 1'b1);
    if (wait_r) wait_q_empty(1'b0, "r_drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    int            len, nb;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst_aw_ready", aw_ready, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_ar_ready", ar_ready, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_r_payload", {r_id, r_data, r_resp, r_last}, 72'd0);
    check("rst_b_payload", {b_id, b_resp}, 7'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill the whole memory so every later read has a known value.
    for (int i = 0; i < 256; i++) begin
      wbuf_d[i] = {$urandom, $urandom};
      wbuf_s[i] = '1;
    end
    do_write(5'd1, 64'h0, 255, 256, 1'b1);

    // Basic burst write then read back.
    for (int i = 0; i < 4; i++) begin
      wbuf_d[i] = 64'(8'h11 * (i + 1));
      wbuf_s[i] = 8'hFF;
    end
    do_write(5'd3, 64'h100, 3, 4, 1'b1);
    do_read(5'd5, 64'h100, 3, 1'b1);

    // Byte strobes merge into the existing word.
    wbuf_d[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbuf_s[0] = 8'hFF;
    do_write(5'd2, 64'h0, 0, 1, 1'b1);
    wbuf_d[0] = 64'hAAAA_AAAA_AAAA_AAAA; wbuf_s[0] = 8'h0F;
    do_write(5'd2, 64'h0, 0, 1, 1'b1);
    do_read(5'd4, 64'h0, 0, 1'b1);

    // Index wrap and out-of-range accesses.
    do_read(5'd6, 64'h7F8, 1, 1'b1);
    do_read(5'd7, 64'h1000, 0, 1'b1);
    wbuf_d[0] = 64'h1234_5678_9ABC_DEF0; wbuf_s[0] = 8'hFF;
    do_write(5'd8, 64'h1000, 0, 1, 1'b1);
    do_read(5'd9, 64'h0, 0, 1'b1);

    // Early and late w_last.
    for (int i = 0; i < 4; i++) begin
      wbuf_d[i] = {$urandom, $urandom};
      wbuf_s[i] = 8'hFF;
    end
    do_write(5'd10, 64'h300, 3, 2, 1'b1);
    do_read(5'd11, 64'h300, 3, 1'b1);
    do_write(5'd12, 64'h340, 1, 4, 1'b1);
    do_read(5'd13, 64'h340, 3, 1'b1);

    // Slow ready pattern: R held three cycles per beat, B held four.
    bp_mode = 2;
    do_write(5'd14, 64'h380, 3, 4, 1'b1);
    do_read(5'd15, 64'h380, 3, 1'b1);

    // Concurrent write and read on disjoint words.
    bp_mode = 1;
    fork
      do_write(5'd16, 64'h000, 3, 4, 1'b1);
      do_read(5'd17, 64'h400, 3, 1'b1);
    join

    // Reset in the middle of a read burst.
    bp_mode = 2;
    do_read(5'd18, 64'h200, 7, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    r_q.delete();
    #1;
    check("midrst_r_valid", r_valid, 1'b0);
    check("midrst_ar_ready", ar_ready, 1'b0);
    check("midrst_r_last", r_last, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      bit seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        seen = ar_ready;
      end
      check("ar_ready_after_rst", seen, 1'b1);
    end
    bp_mode = 0;
    do_read(5'd19, 64'h200, 15, 1'b1);

    // Randomised traffic with random backpressure.
    bp_mode = 1;
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 7);
      nb  = len + 1;
      if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, 9);
      a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      if ($urandom_range(0, 9) == 0) a = a + 64'h800 * 64'($urandom_range(1, 4));
      for (int i = 0; i < nb; i++) begin
        wbuf_d[i] = {$urandom, $urandom};
        wbuf_s[i] = NB'($urandom);
      end
      do_write(IDW'($urandom), a, len, nb, 1'b1);
      a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      if ($urandom_range(0, 9) == 0) a = a + 64'h800 * 64'($urandom_range(1, 4));
      do_read(IDW'($urandom), a, $urandom_range(0, 7), 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("r_queue_drained", r_q.size(), 0);
    check("b_queue_drained", b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name:
axi_mem_responder

Overview:
AXI4 subordinate (responder) that terminates the manager port of the vector-unit wrapper in standalone and unit-level benches and small SoC scratchpads; owns a DEPTH x DATA_WIDTH flop memory, serves INCR bursts on independent read and write paths, and echoes IDs.

Parameters:
AXI_ID_WIDTH, 5, width of aw/ar/b/r id fields
AXI_ADDR_WIDTH, 64, byte address width
AXI_DATA_WIDTH, 64, beat width in bits; every beat is full-width (size = log2(AXI_DATA_WIDTH/8)), INCR only
DEPTH, 256, memory words; power of two; word index = addr[OFS +: IDX] with OFS = $clog2(AXI_DATA_WIDTH/8), IDX = $clog2(DEPTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
axi_req_i_aw_valid  in  1  write address valid
axi_resp_o_aw_ready  out  1  write address ready
axi_req_i_aw_bits_id  in  AXI_ID_WIDTH  write id
axi_req_i_aw_bits_addr  in  AXI_ADDR_WIDTH  write start byte address
axi_req_i_aw_bits_len  in  8  beats minus one
axi_req_i_w_valid  in  1  write data valid
axi_resp_o_w_ready  out  1  write data ready
axi_req_i_w_bits_data  in  AXI_DATA_WIDTH  write data
axi_req_i_w_bits_strb  in  AXI_DATA_WIDTH/8  byte enables
axi_req_i_w_bits_last  in  1  final write beat
axi_resp_o_b_valid  out  1  write response valid
axi_req_i_b_ready  in  1  write response ready
axi_resp_o_b_bits_id  out  AXI_ID_WIDTH  echoed aw id
axi_resp_o_b_bits_resp  out  2  OKAY 2'b00 / SLVERR 2'b10
axi_req_i_ar_valid  in  1  read address valid
axi_resp_o_ar_ready  out  1  read address ready
axi_req_i_ar_bits_id  in  AXI_ID_WIDTH  read id
axi_req_i_ar_bits_addr  in  AXI_ADDR_WIDTH  read start byte address
axi_req_i_ar_bits_len  in  8  beats minus one
axi_resp_o_r_valid  out  1  read data valid
axi_req_i_r_ready  in  1  read data ready
axi_resp_o_r_bits_id  out  AXI_ID_WIDTH  echoed ar id
axi_resp_o_r_bits_data  out  AXI_DATA_WIDTH  read data (0 on SLVERR)
axi_resp_o_r_bits_resp  out  2  OKAY / SLVERR
axi_resp_o_r_bits_last  out  1  final read beat

Behaviour:
- Reset (async, rst_i=1): all valid and ready outputs 0, ids/data/resp/last 0, both FSMs IDLE, beat counters 0; memory contents not reset. Reset mid-burst abandons the burst silently; no B/R issued afterwards.
- Read FSM R_IDLE -> R_BURST: ar_ready=1 only in R_IDLE after reset release; on AR handshake latch id, word index, len, err = (addr[AXI_ADDR_WIDTH-1:OFS+IDX] != 0); r_data register loaded from mem[index] same edge. r_valid=1 the cycle after AR handshake (1-cycle latency). Each R handshake: index = (index+1) mod DEPTH (wrap, no error), reload r_data, count++; r_last=1 when count==len; handshake with r_last returns to R_IDLE (ar_ready next cycle, no back-to-back overlap). r_valid/id/data/resp/last stable while r_ready=0.
- Write FSM W_IDLE -> W_DATA -> W_RESP: aw_ready=1 only in W_IDLE; latch id, index, len, err as read. W_DATA: w_ready=1; each handshake writes bytes with strb=1 into mem[index] (suppressed if err), index wraps mod DEPTH, count++. Handshake with w_last -> W_RESP, b_valid=1 next cycle; resp=SLVERR if err or w_last arrived on beat != len, else OKAY. Beats beyond len before w_last are dropped (no write). W_RESP holds b_valid/id/resp until b_ready, then W_IDLE.
- Read and write commit same word same cycle: read returns old value (r_data sampled before write edge).
- Read and write paths fully independent; aw/w/ar accepted concurrently.

Optional Feature:
AXI_MEM_RESPONDER_RAND_STALL_EN: defined -> 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle; r_valid and w_ready forced 0 when lfsr[1:0]==2'b00 (r payload held). Undefined -> no LFSR, one beat per cycle throughput.

Decomposition:
axi_mem_responder_pkg: RESP_OKAY/RESP_SLVERR constants, r_state_e {R_IDLE,R_BURST}, w_state_e {W_IDLE,W_DATA,W_RESP}. One sub-module: axi_mem_responder_ram (byte-enabled write port, two asynchronous read ports).

Test Plan:
AW id=3 addr=0x100 len=3 + 4 W beats 0x11..0x44 strb 8'hFF, then AR id=5 same addr len=3 -> B id=3 OKAY one cycle after last; R beats 0x11,0x22,0x33,0x44 id=5, r_last on 4th, first r_valid cycle after AR.
Write 64'hFFFF_FFFF_FFFF_FFFF strb 8'hFF then 64'hAAAA_AAAA_AAAA_AAAA strb 8'h0F at 0x0 -> read 64'hFFFF_FFFF_AAAA_AAAA.
AR addr=0x7F8 len=1 -> beats from word 255 then word 0, both OKAY; AR addr=0x1000 len=0 -> data 0, resp 2'b10, last=1; AW 0x1000 -> B SLVERR, memory unchanged.
r_ready low 3 cycles on beat 2 / b_ready low 4 cycles -> R payload and B id/resp stable, aw_ready stays 0; w_last on beat 2 of len=3 -> B SLVERR; rst_i pulse mid-read-burst -> r_valid 0 immediately, ar_ready 1 after release.
